sequenciador_multiciclo: RTL and testbench
==========================================

// Module: sequenciador_multiciclo
// PURPOSE
//  Control FSM for the multiciclo processor datapath (R0-R7, A, G, add/sub ALU, bus mux).
//  Latches a 9-bit instruction from DIN, steps T0..T3, drives every datapath enable
//  (IRin, Rin, Rout, Ain, Gin, Gout, AddSub, DINout) and pulses Done at completion.
//  Replaces the external 2-bit step counter plus combinational decoder with one sequenced block.
// PARAMETERS
//  N_REGS  8  number of general registers; width of Rin/Rout one-hot buses
//  IW      9  instruction width: III XXX YYY (opcode, dest X, src Y)
// PORTS
//  Clock   in   1       single system clock, rising edge
//  Reset   in   1       asynchronous, active-high; forces idle state
//  Run     in   1       start request, sampled only in T0
//  DIN     in   16      data/instruction input; DIN[8:0] is the instruction
//  IRin    out  1       IR load enable (datapath IR copy)
//  Rin     out  N_REGS  register write enables, one-hot, Rin[7-X] selects RX
//  Rout    out  N_REGS  register bus-drive selects, one-hot, Rout[7-Y] selects RY
//  Ain     out  1       load A from bus
//  Gin     out  1       load G from ALU
//  Gout    out  1       G drives bus
//  AddSub  out  1       0 = add, 1 = sub (valid when Gin=1)
//  DINout  out  1       DIN drives bus
//  Done    out  1       one-cycle completion pulse
//  Tstep   out  2       current step, 00=T0..11=T3 (debug/visibility)
// BEHAVIOUR
//  - Reset (async): Tstep=00, ir_q=0; all outputs 0 while Reset high and in first T0.
//  - Outputs are Moore decode of {Tstep, ir_q} except T0 outputs (depend on Run).
//  - Enables are one-hot on the bus: at most one of Rout/Gout/DINout active per cycle.
//  - T0: Run=1 -> IRin=1, ir_q<=DIN[8:0], Tstep->T1. Run=0 -> stay T0, all outputs 0.
//  - Opcodes: 000 mv RX,RY; 001 mvi RX,#DIN; 010 add RX,RY; 011 sub RX,RY; 1xx reserved.
//  - mv  T1: Rout[7-Y]=1, Rin[7-X]=1, Done=1 -> T0.   (latency 2 cycles incl. T0)
//  - mvi T1: DINout=1, Rin[7-X]=1, Done=1 -> T0.  DIN must hold immediate during T1.
//  - add/sub T1: Rout[7-X]=1, Ain=1 -> T2.
//            T2: Rout[7-Y]=1, Gin=1, AddSub=opcode[0] -> T3.
//            T3: Gout=1, Rin[7-X]=1, Done=1 -> T0.    (latency 4 cycles incl. T0)
//  - Reserved 1xx: T1 asserts Done only, no enables, no state change -> T0.
//  - Run ignored outside T0; next instruction accepted in the T0 after Done (back-to-back if Run held).
//  - X==Y legal: mv RX,RX rewrites same value; add RX,RX doubles RX.
//  - Reset mid-instruction: immediate return to T0, all enables drop same instant; partial op abandoned,
//    registers already written keep their values.
//  - Tstep wraps only via explicit return to T0; value 11 never followed by 00 without Done.
//  - ALU arithmetic is 16-bit modulo in datapath; controller has no width dependence on data.
// STRUCTURE
//  - Package proc_pkg: opcode constants (OP_MV, OP_MVI, OP_ADD, OP_SUB), step encodings T0..T3,
//    IW/N_REGS defaults, function onehot_sel(idx) returning 8'b1000_0000 >> idx.
//  - Sub-module contador_passos: 2-bit step register, async Reset, sync Clear (to T0) and Inc.
//  - Top holds ir_q and the combinational output decoder.
// TESTING
//  - Reset, Run=0 5 cycles -> Tstep=00, all outputs 0, Done never asserted.
//  - DIN=9'b001_000_000 then 16'h0005, Run=1 -> T0 IRin=1; T1 DINout=1, Rin=8'h80, Done=1.
//  - mv R1,R0 (000_001_000) -> T1 Rout=8'h80, Rin=8'h40, Done=1; next T0 reached.
//  - add R0,R1 (010_000_001) -> T1 Rout=8'h80,Ain; T2 Rout=8'h40,Gin,AddSub=0; T3 Gout,Rin=8'h80,Done.
//  - sub R2,R1 with Reset pulsed in T2 -> all outputs 0 asynchronously, Tstep=00, no Done; later op clean.
//  - Run held high, mvi then sub then opcode 100 -> back-to-back, Done pulses at T1, T3, T1; no overlap
//    of bus drivers in any cycle (assertion on Rout|Gout|DINout one-hot-or-zero).

Source files
------------

// File: rtl/sequenciador_multiciclo_pkg.sv
// Shared definitions for the multicycle processor controller: opcodes, step
// encodings, default widths and the register one-hot select helper.
package proc_pkg;

  localparam int unsigned IW_DEF     = 9;
  localparam int unsigned N_REGS_DEF = 8;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  typedef enum logic [1:0] {
    T0 = 2'b00,
    T1 = 2'b01,
    T2 = 2'b10,
    T3 = 2'b11
  } step_t;

  // Register index 0 maps to the MSB of the Rin/Rout buses.
  function automatic logic [7:0] onehot_sel(input logic [2:0] idx);
    return 8'b1000_0000 >> idx;
  endfunction

endpackage

// File: rtl/sequenciador_multiciclo_if.sv
// Controller bundle: start/instruction inputs and all datapath enables.
interface sequenciador_multiciclo_if #(
  parameter int unsigned N_REGS = 8
);
  logic              Run;
  logic [15:0]       DIN;
  logic              IRin;
  logic [N_REGS-1:0] Rin;
  logic [N_REGS-1:0] Rout;
  logic              Ain;
  logic              Gin;
  logic              Gout;
  logic              AddSub;
  logic              DINout;
  logic              Done;
  logic [1:0]        Tstep;

  modport master (
    output Run, DIN,
    input  IRin, Rin, Rout, Ain, Gin, Gout, AddSub, DINout, Done, Tstep
  );

  modport slave (
    input  Run, DIN,
    output IRin, Rin, Rout, Ain, Gin, Gout, AddSub, DINout, Done, Tstep
  );
endinterface

// File: rtl/sequenciador_multiciclo_contador_passos.sv
// Two-bit instruction step register: async reset, synchronous clear back to T0
// and increment.
module contador_passos
  import proc_pkg::*;
(
  input  logic  Clock,
  input  logic  Reset,
  input  logic  clear,
  input  logic  inc,
  output step_t step
);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      step <= T0;
    end else if (clear) begin
      step <= T0;
    end else if (inc) begin
      step <= step_t'(step + 2'd1);
    end
  end

endmodule

// File: rtl/sequenciador_multiciclo.sv
// Multicycle processor control: latches the instruction in T0 and decodes
// {step, ir_q} into the datapath enables for T1..T3.
module sequenciador_multiciclo
  import proc_pkg::*;
#(
  parameter int unsigned N_REGS = N_REGS_DEF,
  parameter int unsigned IW     = IW_DEF
) (
  input logic                    Clock,
  input logic                    Reset,
  sequenciador_multiciclo_if.slave bus
);

  step_t             step;
  logic [IW-1:0]     ir_q;
  logic [2:0]        opcode;
  logic [2:0]        x;
  logic [2:0]        y;
  logic              clear;
  logic              inc;
  logic              irin;
  logic [N_REGS-1:0] rin;
  logic [N_REGS-1:0] rout;
  logic              ain;
  logic              gin;
  logic              gout;
  logic              addsub;
  logic              dinout;
  logic              done;
  logic              unused_din;

  assign opcode     = ir_q[8:6];
  assign x          = ir_q[5:3];
  assign y          = ir_q[2:0];
  assign unused_din = ^bus.DIN[15:IW];

  contador_passos u_passos (
    .Clock (Clock),
    .Reset (Reset),
    .clear (clear),
    .inc   (inc),
    .step  (step)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ir_q <= '0;
    end else if (irin) begin
      ir_q <= bus.DIN[IW-1:0];
    end
  end

  // Reset is folded into the T0 decode so IRin cannot leak out while the
  // controller is being held in reset with Run already high.
  always_comb begin
    clear  = 1'b0;
    inc    = 1'b0;
    irin   = 1'b0;
    rin    = '0;
    rout   = '0;
    ain    = 1'b0;
    gin    = 1'b0;
    gout   = 1'b0;
    addsub = 1'b0;
    dinout = 1'b0;
    done   = 1'b0;
    unique case (step)
      T0: begin
        if (bus.Run && !Reset) begin
          irin = 1'b1;
          inc  = 1'b1;
        end
      end
      T1: begin
        unique case (opcode)
          OP_MV: begin
            rout  = N_REGS'(onehot_sel(y));
            rin   = N_REGS'(onehot_sel(x));
            done  = 1'b1;
            clear = 1'b1;
          end
          OP_MVI: begin
            dinout = 1'b1;
            rin    = N_REGS'(onehot_sel(x));
            done   = 1'b1;
            clear  = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            rout = N_REGS'(onehot_sel(x));
            ain  = 1'b1;
            inc  = 1'b1;
          end
          default: begin
            done  = 1'b1;
            clear = 1'b1;
          end
        endcase
      end
      T2: begin
        rout   = N_REGS'(onehot_sel(y));
        gin    = 1'b1;
        addsub = opcode[0];
        inc    = 1'b1;
      end
      T3: begin
        gout  = 1'b1;
        rin   = N_REGS'(onehot_sel(x));
        done  = 1'b1;
        clear = 1'b1;
      end
      default: clear = 1'b1;
    endcase
  end

  assign bus.IRin   = irin;
  assign bus.Rin    = rin;
  assign bus.Rout   = rout;
  assign bus.Ain    = ain;
  assign bus.Gin    = gin;
  assign bus.Gout   = gout;
  assign bus.AddSub = addsub;
  assign bus.DINout = dinout;
  assign bus.Done   = done;
  assign bus.Tstep  = step;

endmodule

// File: tb/tb_sequenciador_multiciclo.sv
// Bench for the multicycle controller: directed vector table, async reset
// abort sequence and randomized run against a micro-op schedule model.
module tb_sequenciador_multiciclo;

  typedef struct packed {
    logic       irin;
    logic [7:0] rin;
    logic [7:0] rout;
    logic       ain;
    logic       gin;
    logic       gout;
    logic       addsub;
    logic       dinout;
    logic       done;
    logic [1:0] tstep;
  } out_t;

  typedef struct {
    logic        run;
    logic [15:0] din;
    out_t        exp;
  } vec_t;

  logic Clock;
  logic Reset;
  int   checks;
  int   errors;

  sequenciador_multiciclo_if #(.N_REGS(8)) bus ();

  sequenciador_multiciclo #(
    .N_REGS (8),
    .IW     (9)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  function automatic out_t mk(input logic irin, input logic [7:0] rin,
                              input logic [7:0] rout, input logic ain,
                              input logic gin, input logic gout,
                              input logic addsub, input logic dinout,
                              input logic done, input logic [1:0] tstep);
    out_t o;
    o.irin = irin; o.rin = rin; o.rout = rout; o.ain = ain; o.gin = gin;
    o.gout = gout; o.addsub = addsub; o.dinout = dinout; o.done = done;
    o.tstep = tstep;
    return o;
  endfunction

  function automatic logic [7:0] sel(input logic [2:0] idx);
    logic [7:0] v;
    v = '0;
    v[7 - idx] = 1'b1;
    return v;
  endfunction

  task automatic check(input string name, input out_t exp);
    out_t act;
    act = mk(bus.IRin, bus.Rin, bus.Rout, bus.Ain, bus.Gin, bus.Gout,
             bus.AddSub, bus.DINout, bus.Done, bus.Tstep);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (irin rin rout ain gin gout addsub dinout done tstep)",
               name, act, exp);
    end
  endtask

  task automatic apply(input logic run, input logic [15:0] din,
                       input out_t exp, input string name);
    bus.Run = run;
    bus.DIN = din;
    #2;
    check(name, exp);
    @(posedge Clock);
    #1;
  endtask

  // Only one source may drive the shared bus in any cycle.
  always @(negedge Clock) begin
    checks++;
    if (!$onehot0(bus.Rout) || !$onehot0({|bus.Rout, bus.Gout, bus.DINout})) begin
      errors++;
      $display("FAIL bus_onehot: got Rout=%h Gout=%b DINout=%b required one-hot-or-zero",
               bus.Rout, bus.Gout, bus.DINout);
    end
  end

  // Reference: an accepted instruction becomes a queue of per-cycle micro-ops.
  out_t sched[$];

  function automatic out_t model_step(input logic run, input logic [15:0] din);
    logic [2:0] op, x, y;
    if (sched.size() != 0) return sched.pop_front();
    if (!run) return '0;
    op = din[8:6];
    x  = din[5:3];
    y  = din[2:0];
    if (op == 3'd0) begin
      sched.push_back(mk(0, sel(x), sel(y), 0, 0, 0, 0, 0, 1, 2'd1));
    end else if (op == 3'd1) begin
      sched.push_back(mk(0, sel(x), '0, 0, 0, 0, 0, 1, 1, 2'd1));
    end else if (op == 3'd2 || op == 3'd3) begin
      sched.push_back(mk(0, '0, sel(x), 1, 0, 0, 0, 0, 0, 2'd1));
      sched.push_back(mk(0, '0, sel(y), 0, 1, 0, op[0], 0, 0, 2'd2));
      sched.push_back(mk(0, sel(x), '0, 0, 0, 1, 0, 0, 1, 2'd3));
    end else begin
      sched.push_back(mk(0, '0, '0, 0, 0, 0, 0, 0, 1, 2'd1));
    end
    return mk(1, '0, '0, 0, 0, 0, 0, 0, 0, 2'd0);
  endfunction

  vec_t vecs[$];
  out_t zero_t0;
  out_t irin_t0;

  initial begin
    checks  = 0;
    errors  = 0;
    zero_t0 = '0;
    irin_t0 = mk(1, '0, '0, 0, 0, 0, 0, 0, 0, 2'd0);

    for (int i = 0; i < 5; i++) vecs.push_back('{1'b0, 16'h0000, zero_t0});
    // mvi R0,#5
    vecs.push_back('{1'b1, 16'h0040, irin_t0});
    vecs.push_back('{1'b0, 16'h0005, mk(0, 8'h80, 8'h00, 0, 0, 0, 0, 1, 1, 2'd1)});
    // mv R1,R0
    vecs.push_back('{1'b1, 16'h0008, irin_t0});
    vecs.push_back('{1'b0, 16'h0000, mk(0, 8'h40, 8'h80, 0, 0, 0, 0, 0, 1, 2'd1)});
    vecs.push_back('{1'b0, 16'h0000, zero_t0});
    // add R0,R1 with Run asserted mid-instruction (ignored)
    vecs.push_back('{1'b1, 16'h0081, irin_t0});
    vecs.push_back('{1'b0, 16'h0000, mk(0, 8'h00, 8'h80, 1, 0, 0, 0, 0, 0, 2'd1)});
    vecs.push_back('{1'b1, 16'h0040, mk(0, 8'h00, 8'h40, 0, 1, 0, 0, 0, 0, 2'd2)});
    vecs.push_back('{1'b0, 16'h0000, mk(0, 8'h80, 8'h00, 0, 0, 1, 0, 0, 1, 2'd3)});
    vecs.push_back('{1'b0, 16'h0000, zero_t0});
    // back-to-back: mvi R0,#AB ; sub R2,R1 ; reserved 100
    vecs.push_back('{1'b1, 16'h0040, irin_t0});
    vecs.push_back('{1'b1, 16'h00AB, mk(0, 8'h80, 8'h00, 0, 0, 0, 0, 1, 1, 2'd1)});
    vecs.push_back('{1'b1, 16'h00D1, irin_t0});
    vecs.push_back('{1'b1, 16'h00D1, mk(0, 8'h00, 8'h20, 1, 0, 0, 0, 0, 0, 2'd1)});
    vecs.push_back('{1'b1, 16'h00D1, mk(0, 8'h00, 8'h40, 0, 1, 0, 1, 0, 0, 2'd2)});
    vecs.push_back('{1'b1, 16'h00D1, mk(0, 8'h20, 8'h00, 0, 0, 1, 0, 0, 1, 2'd3)});
    vecs.push_back('{1'b1, 16'h0100, irin_t0});
    vecs.push_back('{1'b1, 16'h0100, mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 2'd1)});
    vecs.push_back('{1'b0, 16'h0000, zero_t0});
    // add R3,R3 (X==Y)
    vecs.push_back('{1'b1, 16'h009B, irin_t0});
    vecs.push_back('{1'b0, 16'h0000, mk(0, 8'h00, 8'h10, 1, 0, 0, 0, 0, 0, 2'd1)});
    vecs.push_back('{1'b0, 16'h0000, mk(0, 8'h00, 8'h10, 0, 1, 0, 0, 0, 0, 2'd2)});
    vecs.push_back('{1'b0, 16'h0000, mk(0, 8'h10, 8'h00, 0, 0, 1, 0, 0, 1, 2'd3)});
    vecs.push_back('{1'b0, 16'h0000, zero_t0});

    // Reset held with Run high: nothing may be enabled.
    Reset   = 1'b1;
    bus.Run = 1'b1;
    bus.DIN = 16'h0040;
    #3;
    check("reset_hold", zero_t0);
    @(posedge Clock);
    #1;
    check("reset_hold_after_edge", zero_t0);
    Reset = 1'b0;

    foreach (vecs[i]) apply(vecs[i].run, vecs[i].din, vecs[i].exp, $sformatf("vec%0d", i));

    // sub R2,R1 aborted by an asynchronous reset in T2.
    apply(1'b1, 16'h00D1, irin_t0, "abort_t0");
    apply(1'b0, 16'h0000, mk(0, 8'h00, 8'h20, 1, 0, 0, 0, 0, 0, 2'd1), "abort_t1");
    bus.Run = 1'b0;
    #2;
    check("abort_t2_before", mk(0, 8'h00, 8'h40, 0, 1, 0, 1, 0, 0, 2'd2));
    #1;
    Reset = 1'b1;
    #1;
    check("abort_async", zero_t0);
    @(posedge Clock);
    #1;
    check("abort_no_done", zero_t0);
    Reset = 1'b0;
    // mv R3,R4 runs cleanly afterwards
    apply(1'b1, 16'h001C, irin_t0, "post_abort_t0");
    apply(1'b0, 16'h0000, mk(0, 8'h10, 8'h08, 0, 0, 0, 0, 0, 1, 2'd1), "post_abort_t1");
    apply(1'b0, 16'h0000, zero_t0, "post_abort_idle");

    sched.delete();
    for (int i = 0; i < 400; i++) begin
      logic        run;
      logic [15:0] din;
      out_t        exp;
      run = ($urandom_range(0, 3) != 0);
      din = 16'($urandom);
      exp = model_step(run, din);
      apply(run, din, exp, $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
